// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Accepts one operation at a time: latch operands, drive ALU for one cycle, hold the result until consumed.
module alu_share_arb #(
    parameter int unsigned W     = 32,
    parameter int unsigned CTR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CTR_W-1:0] req0_ctr,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CTR_W-1:0] req1_ctr,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [W-1:0]     rsp_c,
    output logic [2:0]       rsp_zero,

    output logic [CTR_W-1:0] alu_ctr,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_c,
    input  logic [2:0]       alu_zero,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             r_gnt_id;
    logic [CTR_W-1:0] r_ctr;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_c;
    logic [2:0]       r_flags;

    logic             w_idle;
    logic             w_pick0;
    logic             w_pick1;
    logic             w_accept;
    logic             w_gnt;
    logic             w_rsp_done;

    // Tie-break favours the requester that did not win last; depends only on
    // req_valid, state and last_grant so rsp_ready never reaches req_ready.
    always_comb begin
        w_idle     = (r_state == IDLE);
        w_pick0    = req0_valid & (~req1_valid | r_last_grant);
        w_pick1    = req1_valid & (~req0_valid | ~r_last_grant);
        req0_ready = w_idle & w_pick0;
        req1_ready = w_idle & w_pick1;
        w_accept   = req0_ready | req1_ready;
        w_gnt      = req1_ready;
    end

    always_comb begin
        rsp0_valid = (r_state == RESP) & ~r_gnt_id;
        rsp1_valid = (r_state == RESP) &  r_gnt_id;
        w_rsp_done = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
        rsp_c      = r_c;
        rsp_zero   = r_flags;
        alu_ctr    = r_ctr;
        alu_a      = r_a;
        alu_b      = r_b;
        busy       = (r_state != IDLE);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = EXEC;
            EXEC:                    w_state_nxt = RESP;
            RESP:    if (w_rsp_done) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ALU inputs come straight from these registers, so they only move on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_gnt_id     <= 1'b0;
            r_ctr        <= '0;
            r_a          <= '0;
            r_b          <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_gnt;
            r_gnt_id     <= w_gnt;
            r_ctr        <= w_gnt ? req1_ctr : req0_ctr;
            r_a          <= w_gnt ? req1_a   : req0_a;
            r_b          <= w_gnt ? req1_b   : req0_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c     <= '0;
            r_flags <= '0;
        end else if (r_state == EXEC) begin
            r_c     <= alu_c;
            r_flags <= alu_zero;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed and randomized bench for alu_share_arb with a behavioural ALU attached.
`timescale 1ns/1ps
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_ctr, req1_ctr;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_c;
    logic [2:0]  rsp_zero;
    logic [4:0]  alu_ctr;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_zero;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.W(32), .CTR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctr(req0_ctr),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctr(req1_ctr),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_c(rsp_c), .rsp_zero(rsp_zero),
        .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_zero(alu_zero),
        .busy(busy)
    );

    function automatic logic [31:0] alu_ref(input logic [4:0] ctr, input logic [31:0] a, input logic [31:0] b);
        case (ctr)
            5'b00000: return a + b;
            5'b00010: return a - b;
            5'b10000: return a - b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] flag_ref(input logic [31:0] c);
        if (c == 32'd0) return 3'b001;
        if (c[31])      return 3'b100;
        return 3'b010;
    endfunction

    always_comb begin
        alu_c    = alu_ref(alu_ctr, alu_a, alu_b);
        alu_zero = flag_ref(alu_c);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_ctr = '0; req0_a = '0; req0_b = '0;
        req1_ctr = '0; req1_a = '0; req1_b = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        #2 rst_n = 1;
        tick();
    endtask

    typedef struct {
        logic        port;
        logic [4:0]  ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [2:0]  f;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] c;
        logic [2:0]  f;
    } exp_t;

    vec_t vecs[8];
    exp_t q[$];

    task automatic run_vec(input vec_t v);
        idle_inputs();
        if (v.port) begin req1_valid = 1; req1_ctr = v.ctr; req1_a = v.a; req1_b = v.b; end
        else        begin req0_valid = 1; req0_ctr = v.ctr; req0_a = v.a; req0_b = v.b; end
        #1;
        check("vec_rdy_win",  v.port ? req1_ready : req0_ready, 1);
        check("vec_rdy_lose", v.port ? req0_ready : req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        #1;
        check("vec_exec_busy", busy, 1);
        check("vec_alu_ctr", alu_ctr, v.ctr);
        check("vec_alu_a", alu_a, v.a);
        check("vec_alu_b", alu_b, v.b);
        check("vec_exec_rspv", rsp0_valid | rsp1_valid, 0);
        tick();
        check("vec_rspv_win",  v.port ? rsp1_valid : rsp0_valid, 1);
        check("vec_rspv_lose", v.port ? rsp0_valid : rsp1_valid, 0);
        check("vec_rsp_c", rsp_c, v.c);
        check("vec_rsp_zero", rsp_zero, v.f);
        if (v.port) rsp1_ready = 1; else rsp0_ready = 1;
        tick();
        rsp0_ready = 0; rsp1_ready = 0;
        #1;
        check("vec_back_idle", busy, 0);
        check("vec_idle_rspv", rsp0_valid | rsp1_valid, 0);
    endtask

    initial begin
        int          g_cnt, last_cyc, accepted, responded;
        logic [3:0]  g_seq;
        logic        acc0, acc1;
        logic [4:0]  ops[4];

        vecs[0] = '{1'b0, 5'b00000, 32'd5,          32'd7, 32'd12,         3'b010};
        vecs[1] = '{1'b1, 5'b00010, 32'd3,          32'd3, 32'd0,          3'b001};
        vecs[2] = '{1'b0, 5'b10000, 32'd1,          32'd2, 32'hFFFF_FFFF,  3'b100};
        vecs[3] = '{1'b1, 5'b10000, 32'd2,          32'd1, 32'd1,          3'b010};
        vecs[4] = '{1'b0, 5'b00101, 32'd9,          32'd9, 32'd0,          3'b001};
        vecs[5] = '{1'b1, 5'b00000, 32'hFFFF_FFFF,  32'd1, 32'd0,          3'b001};
        vecs[6] = '{1'b0, 5'b00010, 32'd0,          32'd1, 32'hFFFF_FFFF,  3'b100};
        vecs[7] = '{1'b1, 5'b00000, 32'h7FFF_FFFF,  32'd1, 32'h8000_0000,  3'b100};
        ops[0] = 5'b00000; ops[1] = 5'b00010; ops[2] = 5'b10000; ops[3] = 5'b01111;

        idle_inputs();
        rst_n = 0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_rspv", rsp0_valid | rsp1_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_ctr", alu_ctr, 0);
        check("rst_rsp_c", rsp_c, 0);
        check("rst_rsp_zero", rsp_zero, 0);
        tick();
        #2 rst_n = 1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Both ports requesting continuously, responses always consumed.
        apply_reset();
        req0_valid = 1; req0_ctr = 5'b00000; req0_a = 32'd10; req0_b = 32'd20;
        req1_valid = 1; req1_ctr = 5'b00010; req1_a = 32'd3;  req1_b = 32'd3;
        rsp0_ready = 1; rsp1_ready = 1;
        g_cnt = 0; g_seq = '0; last_cyc = 0;
        for (int cyc = 0; cyc < 30 && g_cnt < 4; cyc++) begin
            #1;
            if (req0_ready && req1_ready) check("alt_both_ready", 1, 0);
            if (rsp0_valid) begin
                check("alt_rsp0_c", rsp_c, 32'd30);
                check("alt_rsp0_z", rsp_zero, 3'b010);
            end
            if (rsp1_valid) begin
                check("alt_rsp1_c", rsp_c, 32'd0);
                check("alt_rsp1_z", rsp_zero, 3'b001);
            end
            if (req0_ready || req1_ready) begin
                g_seq[g_cnt] = req1_ready;
                if (g_cnt > 0) check("alt_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                g_cnt++;
            end
            tick();
        end
        check("alt_grant_count", g_cnt, 4);
        check("alt_grant_seq", {28'd0, g_seq}, 32'b1010);
        apply_reset();

        // Backpressure on port 1 while port 0 waits.
        req1_valid = 1; req1_ctr = 5'b00000; req1_a = 32'd100; req1_b = 32'd23;
        #1;
        check("bp_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_ctr = 5'b00000; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        check("bp_exec_req0_ready", req0_ready, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            check("bp_rsp1_valid", rsp1_valid, 1);
            check("bp_rsp0_valid", rsp0_valid, 0);
            check("bp_rsp_c", rsp_c, 32'd123);
            check("bp_rsp_zero", rsp_zero, 3'b010);
            check("bp_req0_ready", req0_ready, 0);
            tick();
        end
        rsp1_ready = 1;
        #1;
        check("bp_release_rsp1_valid", rsp1_valid, 1);
        check("bp_no_comb_path", req0_ready, 0);
        tick();
        rsp1_ready = 0;
        #1;
        check("bp_req0_next", req0_ready, 1);
        tick();
        req0_valid = 0;
        tick();
        check("bp_rsp0_valid", rsp0_valid, 1);
        check("bp_rsp0_c", rsp_c, 32'd12);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;

        // Asynchronous reset mid-EXEC, then mid-RESP.
        req0_valid = 1; req0_ctr = 5'b00000; req0_a = 32'd5; req0_b = 32'd7;
        tick();
        req0_valid = 0;
        check("ax_exec_alu_a", alu_a, 32'd5);
        #2 rst_n = 0;
        #1;
        check("ax_busy", busy, 0);
        check("ax_alu_a", alu_a, 0);
        check("ax_alu_b", alu_b, 0);
        #1 rst_n = 1;
        req0_valid = 1; req1_valid = 1;
        req1_ctr = 5'b00000; req1_a = 32'd1; req1_b = 32'd1;
        #1;
        check("ax_tie_req0", req0_ready, 1);
        check("ax_tie_req1", req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        check("ar_rsp0_valid", rsp0_valid, 1);
        check("ar_rsp_c_pre", rsp_c, 32'd12);
        #2 rst_n = 0;
        #1;
        check("ar_rsp0_valid_rst", rsp0_valid, 0);
        check("ar_rsp_c_rst", rsp_c, 0);
        check("ar_rsp_zero_rst", rsp_zero, 0);
        check("ar_alu_a_rst", alu_a, 0);
        #1 rst_n = 1;
        tick();
        tick();
        check("ar_no_stale", rsp0_valid | rsp1_valid | busy, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        check("ar_tie_req0", req0_ready, 1);
        check("ar_tie_req1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        tick();

        // Randomized traffic against a scoreboard.
        accepted = 0; responded = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1; req0_ctr = ops[$urandom_range(0, 3)];
                req0_a = $urandom(); req0_b = $urandom_range(0, 1) ? $urandom() : req0_a;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1; req1_ctr = ops[$urandom_range(0, 3)];
                req1_a = $urandom(); req1_b = $urandom();
            end
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            #1;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (busy) check("rnd_ready_busy", req0_ready | req1_ready, 0);
            if (acc0) begin
                q.push_back('{1'b0, alu_ref(req0_ctr, req0_a, req0_b), flag_ref(alu_ref(req0_ctr, req0_a, req0_b))});
                accepted++;
            end
            if (acc1) begin
                q.push_back('{1'b1, alu_ref(req1_ctr, req1_a, req1_b), flag_ref(alu_ref(req1_ctr, req1_a, req1_b))});
                accepted++;
            end
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                responded++;
                if (q.size() == 0) check("rnd_unexpected_rsp", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rnd_port", rsp1_valid, e.port);
                    check("rnd_c", rsp_c, e.c);
                    check("rnd_zero", rsp_zero, e.f);
                end
            end
            tick();
            if (acc0) req0_valid = 0;
            if (acc1) req1_valid = 0;
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rsp0_valid || rsp1_valid) begin
                responded++;
                if (q.size() == 0) check("rnd_unexpected_rsp", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rnd_port", rsp1_valid, e.port);
                    check("rnd_c", rsp_c, e.c);
                    check("rnd_zero", rsp_zero, e.f);
                end
            end
            tick();
        end
        check("rnd_queue_empty", q.size(), 0);
        check("rnd_rsp_count", responded, accepted);
        check("rnd_some_traffic", accepted > 20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port round-robin arbiter and sequencer that time-shares the single combinational 32-bit ALU between requester 0 (pipeline EX stage) and requester 1 (auxiliary compare/address unit). It registers the granted operands, drives them onto the ALU for one cycle, captures the ALU result and 3-bit condition flags, and returns them to the winning requester over a valid/ready response channel. One operation is in flight at a time.

## Interface
- W, default 32: operand/result width.
- CTR_W, default 5: ALU control width.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1: request present.
- req0_ready / req1_ready  out  1: request accepted this cycle when valid & ready.
- req0_ctr / req1_ctr  in  CTR_W: ALU opcode.
- req0_a, req0_b / req1_a, req1_b  in  W: operands.
- rsp0_valid / rsp1_valid  out  1: result available for that requester.
- rsp0_ready / rsp1_ready  in  1: requester consumes result.
- rsp_c  out  W: result, shared by both response ports.
- rsp_zero  out  3: captured flags {neg, pos, zero}, shared.
- alu_ctr  out  CTR_W; alu_a, alu_b  out  W: to ALU.
- alu_c  in  W; alu_zero  in  3: from ALU.
- busy  out  1: state != IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: req_ready of a requester is high iff it is the grant choice this cycle (at most one ready high). Grant: only one valid -> that one; both valid -> the one not equal to last_grant. On handshake: latch ctr/a/b into operand registers, latch grant id, update last_grant, go EXEC.
- EXEC (exactly 1 cycle): alu_ctr/alu_a/alu_b show latched operands (registered outputs, stable for the whole cycle); at cycle end capture alu_c, alu_zero into result registers; go RESP.
- RESP: rspN_valid high for latched id only; rsp_c/rsp_zero held constant. When rspN_ready high -> go IDLE. Stays in RESP indefinitely otherwise; no new requests accepted (both req_ready low).
- req_ready low in EXEC and RESP; requests held by requesters, not dropped.
- Opcodes passed through unchecked; undefined codes yield whatever ALU returns (0).
- Compare opcode 5'b10000 needs no special handling; flags come from ALU.
- Reset (any state, incl. mid-EXEC/RESP): state IDLE, last_grant = 1 (req0 wins first tie), operand/result registers 0, alu_ctr/alu_a/alu_b 0, all rsp_valid 0, busy 0; in-flight result discarded.

## Timing
- Request handshake cycle T; ALU driven during T+1; rspN_valid rises at T+2 (latency 2).
- Response consumed in cycle R (valid & ready) -> IDLE at R+1; next request accepted earliest R+1. Max throughput 1 op / 3 cycles.
- req_ready is combinational from req_valid, state, last_grant; no combinational path from rsp_ready to req_ready.
- alu_* outputs change only on clk edges; hold last operands outside EXEC (no glitching on ALU inputs).
- Simultaneous valid on both ports with rsp pending: neither accepted until IDLE; arbitration evaluated fresh then.

## Test plan
- Reset then req0 only: ctr=00000, a=5, b=7 at T -> req0_ready=1 at T, alu_a=5/alu_b=7 at T+1, rsp0_valid=1 at T+2 with rsp_c=12, rsp_zero=3'b010, rsp1_valid=0.
- Both valid continuously, rsp_ready tied high: grants alternate 0,1,0,1 (first req0); req1 ctr=00010 a=3 b=3 -> rsp_c=0, rsp_zero=3'b001.
- Backpressure: rsp1_ready held low 10 cycles -> rsp1_valid and rsp_c stable throughout, req0_ready=0 though req0_valid=1; release -> req0 accepted next cycle.
- Compare op 10000 a=1 b=2 -> rsp_zero[2]=1 (borrow); a=2 b=1 -> rsp_zero[1]=1.
- rst_n asserted asynchronously mid-EXEC and mid-RESP -> outputs zero immediately without clock; after release, no stale rsp_valid, req0 wins tie.
- Random stimulus vs. reference model: every accepted request gets exactly one response, to the correct port, in order, with result equal to ALU golden model.
